decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised instruction queue between the frontend and decode. Replaces the single decode pipe register with a DEPTH-entry FIFO holding {instr, pc, instruction_addr_misaligned} per entry, using valid/ready handshakes on both sides and a single-cycle flush. Decode logic reads the head entry directly. Frontend fetch therefore continues across short scoreboard stalls without the stallnum-based hold logic.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2
- XLEN, 32, width of pc and instruction
- NOP_INSTR, 32'h0000_0013, value driven on instr3 while the queue is empty

Ports:
- clk  in  1  clock. One clock domain; all state updates on the rising edge.
- nrst  in  1  reset, asynchronous, active-low; clears all state.
- pc2  in  XLEN  frontend pc
- instr2  in  XLEN  frontend instruction
- instruction_addr_misaligned2  in  1  frontend exception flag, stored with the entry
- valid2  in  1  frontend offers an entry
- ready2  out  1  queue accepts an entry; equals !full
- pc3  out  XLEN  head entry pc
- instr3  out  XLEN  head entry instruction
- instruction_addr_misaligned3  out  1  head entry exception flag
- valid3  out  1  head entry present; equals !empty
- ready3  in  1  decode/issue consumes the head; driven as !stall by the scoreboard
- flush  in  1  discard all entries (redirect, or exception_pending from commit)
- count  out  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Storage: DEPTH-entry array plus rd_ptr and wr_ptr, each $clog2(DEPTH)+1 bits.
  - Pointers wrap modulo 2·DEPTH; the MSB distinguishes full from empty.
  - empty = (rd_ptr == wr_ptr).
  - full = (index bits equal) && (MSBs differ).
  - count = wr_ptr − rd_ptr, computed modulo 2^(ptr width).
- push = valid2 && ready2 && !flush. On push, write the entry at wr_ptr[index] and increment wr_ptr.
- pop = valid3 && ready3 && !flush. On pop, increment rd_ptr.
- Simultaneous push and pop (queue neither empty nor full): both pointers advance and count is unchanged.
- Full queue: ready2 = 0 even if a pop happens in the same cycle. There is no combinational ready path from ready3 to ready2.
- Empty queue: a pop is impossible because valid3 = 0; ready3 is ignored.
- Flush:
  - rd_ptr <= wr_ptr, and the push in the same cycle is dropped.
  - Storage contents are not cleared.
  - Next cycle: valid3 = 0, count = 0, ready2 = 1.
  - Flush has priority over both push and pop.
- Outputs are combinational reads of the array at rd_ptr[index].
  - When empty: instr3 = NOP_INSTR, pc3 = 0, instruction_addr_misaligned3 = 0.
  - The head outputs are stable while valid3 = 1 and ready3 = 0.
- Order is strict FIFO. The misaligned flag travels with its own entry only.

## Timing
- Reset (nrst low, asynchronous): rd_ptr = wr_ptr = 0. All outputs then read:
  - valid3 = 0, ready2 = 1, count = 0
  - instr3 = NOP_INSTR (32'h0000_0013), pc3 = 0, instruction_addr_misaligned3 = 0
- Reset asserted mid-operation empties the queue immediately, without waiting for a clock edge.
- Entries pushed before reset are lost. Storage is not reset.
- Latency: an entry pushed at edge N appears on valid3/instr3 after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Sustained throughput: one entry per cycle when valid2 = ready3 = 1 and the queue is neither full nor empty.
- ready2 and valid3 depend only on the pointers (registered state). There is no combinational path from any input to ready2 or valid3.

## Test plan
- Reset and fill:
  - Stimulus: release nrst; push pc 0x100, 0x104, 0x108, 0x10C with instr 0xA..0xD; hold ready3 = 0.
  - Required: after the 4th push, count = 4 and ready2 = 0. A 5th valid2 is not accepted. instr3 stays 0xA and pc3 stays 0x100.
- Drain in order:
  - Stimulus: from full, set ready3 = 1 with valid2 = 0.
  - Required: pc3 reads 0x100, 0x104, 0x108, 0x10C on consecutive cycles. Then valid3 = 0 and instr3 = 0x00000013.
- Streaming and pointer wrap:
  - Stimulus: valid2 = ready3 = 1 for 20 cycles with incrementing pc.
  - Required: count stays at 1 after the first cycle. pc3 follows pc2 with a one-cycle lag. No entry is lost across pointer wrap.
- Flush with simultaneous push:
  - Stimulus: 3 entries queued; assert flush for one cycle while valid2 = 1 with pc 0x200.
  - Required: next cycle valid3 = 0, count = 0, and 0x200 is absent. A push in the following cycle appears normally.
- Exception flag tagging:
  - Stimulus: push entries A (misaligned = 0), B (misaligned = 1), C (misaligned = 0); then pop all three.
  - Required: instruction_addr_misaligned3 = 1 only while B is at the head.
- Asynchronous reset mid-stream:
  - Stimulus: with 2 entries queued, assert nrst low between clock edges.
  - Required: valid3 = 0 and count = 0 immediately, before the next edge, with all outputs at their reset values.

Source files
------------

// File: rtl/decode_queue_if.sv
// Frontend-to-decode handshake bundle around the decode queue.
// master: frontend/decode/commit side, slave: the queue itself.
interface decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc2;
  logic [XLEN-1:0] instr2;
  logic            instruction_addr_misaligned2;
  logic            valid2;
  logic            ready2;

  logic [XLEN-1:0] pc3;
  logic [XLEN-1:0] instr3;
  logic            instruction_addr_misaligned3;
  logic            valid3;
  logic            ready3;

  logic            flush;
  logic [CW-1:0]   count;

  modport master (
    output pc2,
    output instr2,
    output instruction_addr_misaligned2,
    output valid2,
    input  ready2,
    input  pc3,
    input  instr3,
    input  instruction_addr_misaligned3,
    input  valid3,
    output ready3,
    output flush,
    input  count
  );

  modport slave (
    input  pc2,
    input  instr2,
    input  instruction_addr_misaligned2,
    input  valid2,
    output ready2,
    output pc3,
    output instr3,
    output instruction_addr_misaligned3,
    output valid3,
    input  ready3,
    input  flush,
    output count
  );
endinterface

// File: rtl/decode_queue.sv
// DEPTH-entry instruction FIFO between frontend and decode.
// Head entry is read combinationally; flush drops everything in one cycle.
module decode_queue #(
  parameter int              DEPTH     = 4,
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 'h0000_0013
) (
  input  logic          clk,
  input  logic          nrst,
  decode_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            mis;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   diff;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  // Extra pointer MSB separates the full and empty cases.
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) &&
                 (rd_ptr[AW] != wr_ptr[AW]);

  assign push = q.valid2 && !full && !q.flush;
  assign pop  = !empty && q.ready3 && !q.flush;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (q.flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{
        instr: q.instr2,
        pc:    q.pc2,
        mis:   q.instruction_addr_misaligned2
      };
    end
  end

  assign head = mem[rd_ptr[AW-1:0]];
  assign diff = wr_ptr - rd_ptr;

  assign q.ready2 = !full;
  assign q.valid3 = !empty;
  assign q.count  = CW'(diff);

  assign q.instr3 = empty ? NOP_INSTR : head.instr;
  assign q.pc3    = empty ? '0 : head.pc;
  assign q.instruction_addr_misaligned3 = !empty && head.mis;
endmodule

// File: tb/tb_decode_queue.sv
// Directed-vector bench for decode_queue.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_decode_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic nrst;
  int   n_chk;
  int   n_fail;

  decode_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  decode_queue #(
    .DEPTH(DEPTH),
    .XLEN(XLEN),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .q(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(
    input logic [31:0] pc,
    input logic [31:0] ins,
    input logic        mis
  );
    bus.pc2    = pc;
    bus.instr2 = ins;
    bus.instruction_addr_misaligned2 = mis;
    bus.valid2 = 1'b1;
    step();
    bus.valid2 = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, ".valid3"}, 64'(bus.valid3), 64'd0);
    check({tag, ".ready2"}, 64'(bus.ready2), 64'd1);
    check({tag, ".count"},  64'(bus.count),  64'd0);
    check({tag, ".instr3"}, 64'(bus.instr3), 64'h13);
    check({tag, ".pc3"},    64'(bus.pc3),    64'd0);
    check({tag, ".mis3"},
          64'(bus.instruction_addr_misaligned3), 64'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    nrst   = 1'b0;
    bus.pc2    = '0;
    bus.instr2 = '0;
    bus.instruction_addr_misaligned2 = 1'b0;
    bus.valid2 = 1'b0;
    bus.ready3 = 1'b0;
    bus.flush  = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
    nrst = 1'b1;
    step();

    // fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      push(32'h100 + 32'(4 * i), 32'hA + 32'(i), 1'b0);
      check("fill.count", 64'(bus.count), 64'(i + 1));
    end
    check("full.ready2", 64'(bus.ready2), 64'd0);
    check("full.valid3", 64'(bus.valid3), 64'd1);
    push(32'h110, 32'hE, 1'b0);
    check("full.count5", 64'(bus.count), 64'd4);
    check("full.instr3", 64'(bus.instr3), 64'hA);
    check("full.pc3",    64'(bus.pc3),    64'h100);

    // drain
    bus.ready3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain.pc3", 64'(bus.pc3), 64'(32'h100 + 4 * i));
      step();
    end
    check("drain.valid3", 64'(bus.valid3), 64'd0);
    check("drain.instr3", 64'(bus.instr3), 64'h13);
    check("drain.ready2", 64'(bus.ready2), 64'd1);

    // stream across pointer wrap
    bus.valid2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.pc2    = 32'h1000 + 32'(4 * i);
      bus.instr2 = 32'h5000 + 32'(i);
      step();
      check("strm.count", 64'(bus.count), 64'd1);
      check("strm.pc3", 64'(bus.pc3), 64'(32'h1000 + 4 * i));
      check("strm.instr3", 64'(bus.instr3), 64'(32'h5000 + i));
    end
    bus.valid2 = 1'b0;
    step();
    check("strm.end", 64'(bus.count), 64'd0);
    bus.ready3 = 1'b0;

    // flush with simultaneous push
    push(32'h300, 32'h30, 1'b0);
    push(32'h304, 32'h31, 1'b0);
    push(32'h308, 32'h32, 1'b0);
    check("fl.pre", 64'(bus.count), 64'd3);
    bus.flush  = 1'b1;
    bus.valid2 = 1'b1;
    bus.pc2    = 32'h200;
    bus.instr2 = 32'h20;
    step();
    bus.flush  = 1'b0;
    bus.valid2 = 1'b0;
    check("fl.valid3", 64'(bus.valid3), 64'd0);
    check("fl.count",  64'(bus.count),  64'd0);
    check("fl.ready2", 64'(bus.ready2), 64'd1);
    check("fl.pc3",    64'(bus.pc3),    64'd0);
    push(32'h400, 32'h40, 1'b0);
    check("fl.after.valid", 64'(bus.valid3), 64'd1);
    check("fl.after.pc3",   64'(bus.pc3),    64'h400);
    check("fl.after.count", 64'(bus.count),  64'd1);
    bus.ready3 = 1'b1;
    step();
    bus.ready3 = 1'b0;
    check("fl.pop", 64'(bus.count), 64'd0);

    // misaligned flag stays with its own entry
    push(32'h500, 32'h50, 1'b0);
    push(32'h504, 32'h51, 1'b1);
    push(32'h508, 32'h52, 1'b0);
    bus.ready3 = 1'b1;
    check("mis.A", 64'(bus.instruction_addr_misaligned3), 64'd0);
    check("mis.A.pc", 64'(bus.pc3), 64'h500);
    step();
    check("mis.B", 64'(bus.instruction_addr_misaligned3), 64'd1);
    check("mis.B.pc", 64'(bus.pc3), 64'h504);
    step();
    check("mis.C", 64'(bus.instruction_addr_misaligned3), 64'd0);
    check("mis.C.pc", 64'(bus.pc3), 64'h508);
    step();
    check("mis.empty", 64'(bus.instruction_addr_misaligned3), 64'd0);
    check("mis.valid3", 64'(bus.valid3), 64'd0);
    bus.ready3 = 1'b0;

    // asynchronous reset between edges
    push(32'h600, 32'h60, 1'b1);
    push(32'h604, 32'h61, 1'b0);
    check("ar.pre", 64'(bus.count), 64'd2);
    #2;
    nrst = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    nrst = 1'b1;
    step();
    check("ar.post", 64'(bus.count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
